// File: rtl/mem_req_arb_if.sv
// Bundle of client request/response, shim request/response and status signals for mem_req_arb.
// The slave modport is the arbiter's view; the master modport is the clients'/shim's view.
interface mem_req_arb_if;
    logic [1:0]  c0_req_cmd;
    logic [21:0] c0_req_addr;
    logic [63:0] c0_req_dta;
    logic        c0_req_valid;
    logic        c0_req_ready;
    logic [1:0]  c1_req_cmd;
    logic [21:0] c1_req_addr;
    logic [63:0] c1_req_dta;
    logic        c1_req_valid;
    logic        c1_req_ready;
    logic [1:0]  c2_req_cmd;
    logic [21:0] c2_req_addr;
    logic [63:0] c2_req_dta;
    logic        c2_req_valid;
    logic        c2_req_ready;

    logic [1:0]  mem_req_rd_cmd;
    logic [21:0] mem_req_rd_addr;
    logic [63:0] mem_req_rd_dta;
    logic        mem_req_rd_valid;
    logic        mem_req_rd_en;
    logic [63:0] mem_res_wr_dta;
    logic        mem_res_wr_en;
    logic        mem_res_wr_almost_full;

    logic [63:0] c0_res_dta;
    logic        c0_res_valid;
    logic        c0_res_almost_full;
    logic [63:0] c1_res_dta;
    logic        c1_res_valid;
    logic        c1_res_almost_full;
    logic [63:0] c2_res_dta;
    logic        c2_res_valid;
    logic        c2_res_almost_full;
    logic        err_orphan_rsp;

    modport slave (
        input  c0_req_cmd, c0_req_addr, c0_req_dta, c0_req_valid,
        input  c1_req_cmd, c1_req_addr, c1_req_dta, c1_req_valid,
        input  c2_req_cmd, c2_req_addr, c2_req_dta, c2_req_valid,
        output c0_req_ready, c1_req_ready, c2_req_ready,
        output mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid,
        input  mem_req_rd_en, mem_res_wr_dta, mem_res_wr_en,
        output mem_res_wr_almost_full,
        output c0_res_dta, c0_res_valid, c1_res_dta, c1_res_valid, c2_res_dta, c2_res_valid,
        input  c0_res_almost_full, c1_res_almost_full, c2_res_almost_full,
        output err_orphan_rsp
    );

    modport master (
        output c0_req_cmd, c0_req_addr, c0_req_dta, c0_req_valid,
        output c1_req_cmd, c1_req_addr, c1_req_dta, c1_req_valid,
        output c2_req_cmd, c2_req_addr, c2_req_dta, c2_req_valid,
        input  c0_req_ready, c1_req_ready, c2_req_ready,
        input  mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid,
        output mem_req_rd_en, mem_res_wr_dta, mem_res_wr_en,
        input  mem_res_wr_almost_full,
        input  c0_res_dta, c0_res_valid, c1_res_dta, c1_res_valid, c2_res_dta, c2_res_valid,
        output c0_res_almost_full, c1_res_almost_full, c2_res_almost_full,
        input  err_orphan_rsp
    );
endinterface

// File: rtl/mem_req_arb.sv
// Three-client memory request arbiter with a one-entry output register and a read-tag FIFO
// that routes responses back to the issuing client. Define MEM_ARB_C0_PRIO_EN to give client 0 strict priority.
module mem_req_arb #(
    parameter int TAG_DEPTH = 16,
    parameter int AF_LEVEL  = 12
) (
    input logic         clk,
    input logic         rst_n,
    mem_req_arb_if.slave bus
);
    localparam int         PW       = $clog2(TAG_DEPTH);
    localparam logic [1:0] CMD_READ = 2'd2;
    localparam logic [PW:0]   DEPTH_V = (PW+1)'(TAG_DEPTH);
    localparam logic [PW:0]   AF_V    = (PW+1)'(AF_LEVEL);
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]  w_cmd  [3];
    logic [21:0] w_addr [3];
    logic [63:0] w_dta  [3];
    logic [2:0]  w_valid;
    logic [2:0]  w_res_af;
    logic [2:0]  w_elig;
    logic        w_gnt_valid;
    logic [1:0]  w_gnt_id;
    logic        w_load;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_pop_id;
    logic [PW:0] w_cnt_next;

    logic        r_valid;
    logic [1:0]  r_cmd;
    logic [21:0] r_addr;
    logic [63:0] r_dta;
    logic [1:0]  r_id;
    logic [1:0]  r_last;
    logic [1:0]  r_tag [TAG_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [2:0]  r_res_valid;
    logic [63:0] r_res_dta [3];
    logic        r_af;
    logic        r_err;

    assign w_cmd[0]  = bus.c0_req_cmd;
    assign w_cmd[1]  = bus.c1_req_cmd;
    assign w_cmd[2]  = bus.c2_req_cmd;
    assign w_addr[0] = bus.c0_req_addr;
    assign w_addr[1] = bus.c1_req_addr;
    assign w_addr[2] = bus.c2_req_addr;
    assign w_dta[0]  = bus.c0_req_dta;
    assign w_dta[1]  = bus.c1_req_dta;
    assign w_dta[2]  = bus.c2_req_dta;
    assign w_valid   = {bus.c2_req_valid, bus.c1_req_valid, bus.c0_req_valid};
    assign w_res_af  = {bus.c2_res_almost_full, bus.c1_res_almost_full, bus.c0_res_almost_full};

    assign w_push = r_valid && bus.mem_req_rd_en && (r_cmd == CMD_READ);
    assign w_pop  = bus.mem_res_wr_en && (r_count != '0);
    assign w_pop_id = r_tag[r_rd_ptr];

    always_comb begin
        w_cnt_next = r_count;
        if (w_push && !w_pop)
            w_cnt_next = r_count + CNT_ONE;
        else if (!w_push && w_pop)
            w_cnt_next = r_count - CNT_ONE;
    end

    // A READ may only be granted if its tag is guaranteed a slot once it is issued.
    always_comb begin
        for (int i = 0; i < 3; i++)
            w_elig[i] = w_valid[i] && ((w_cmd[i] != CMD_READ) || (w_cnt_next < DEPTH_V));
    end

`ifdef MEM_ARB_C0_PRIO_EN
    always_comb begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 2'd0;
        if (w_elig[0])
            w_gnt_id = 2'd0;
        else if (w_elig[1] && w_elig[2])
            w_gnt_id = (r_last == 2'd1) ? 2'd2 : 2'd1;
        else if (w_elig[1])
            w_gnt_id = 2'd1;
        else if (w_elig[2])
            w_gnt_id = 2'd2;
        else
            w_gnt_valid = 1'b0;
    end
`else
    logic [1:0] w_order [3];

    always_comb begin
        case (r_last)
            2'd0:    w_order = '{2'd1, 2'd2, 2'd0};
            2'd1:    w_order = '{2'd2, 2'd0, 2'd1};
            default: w_order = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    // Scanning from the back lets the earliest eligible client in rotated order win.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (w_elig[w_order[k]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = w_order[k];
            end
        end
    end
`endif

    assign w_load   = !r_valid || bus.mem_req_rd_en;
    assign w_accept = rst_n && w_load && w_gnt_valid;

    assign bus.c0_req_ready = w_accept && (w_gnt_id == 2'd0);
    assign bus.c1_req_ready = w_accept && (w_gnt_id == 2'd1);
    assign bus.c2_req_ready = w_accept && (w_gnt_id == 2'd2);

    // Illegal commands (MSB clear) are consumed on grant but leave the output register empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_cmd   <= 2'd0;
            r_addr  <= 22'd0;
            r_dta   <= 64'd0;
            r_id    <= 2'd0;
            r_last  <= 2'd2;
        end else if (w_load) begin
`ifdef MEM_ARB_C0_PRIO_EN
            if (w_gnt_valid && (w_gnt_id != 2'd0))
                r_last <= w_gnt_id;
`else
            if (w_gnt_valid)
                r_last <= w_gnt_id;
`endif
            if (w_gnt_valid && w_cmd[w_gnt_id][1]) begin
                r_valid <= 1'b1;
                r_cmd   <= w_cmd[w_gnt_id];
                r_addr  <= w_addr[w_gnt_id];
                r_dta   <= w_dta[w_gnt_id];
                r_id    <= w_gnt_id;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_tag[r_wr_ptr] <= r_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 3'b000;
            r_res_dta   <= '{64'd0, 64'd0, 64'd0};
            r_af        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 3'b000;
            if (w_pop) begin
                r_res_valid[w_pop_id] <= 1'b1;
                r_res_dta[w_pop_id]   <= bus.mem_res_wr_dta;
            end
            if (bus.mem_res_wr_en && (r_count == '0))
                r_err <= 1'b1;
            r_af <= (w_cnt_next >= AF_V) || (|w_res_af);
        end
    end

    assign bus.mem_req_rd_valid = r_valid;
    assign bus.mem_req_rd_cmd   = r_cmd;
    assign bus.mem_req_rd_addr  = r_addr;
    assign bus.mem_req_rd_dta   = r_dta;
    assign bus.mem_res_wr_almost_full = r_af;
    assign bus.c0_res_valid = r_res_valid[0];
    assign bus.c1_res_valid = r_res_valid[1];
    assign bus.c2_res_valid = r_res_valid[2];
    assign bus.c0_res_dta   = r_res_dta[0];
    assign bus.c1_res_dta   = r_res_dta[1];
    assign bus.c2_res_dta   = r_res_dta[2];
    assign bus.err_orphan_rsp = r_err;
endmodule

// File: tb/tb_mem_req_arb.sv
// Self-checking bench for mem_req_arb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model (grant order, tag queue, routing).
module tb_mem_req_arb;
    localparam int TAG_DEPTH = 16;
    localparam int AF_LEVEL  = 12;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    mem_req_arb_if bus();

    mem_req_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: head register contents, ordered outstanding-read IDs, arbitration history.
    logic        mValid;
    logic [1:0]  mCmd;
    logic [21:0] mAddr;
    logic [63:0] mDta;
    int          mId;
    int          tagQ[$];
    int          mLast;
    int          mLast12;
    logic [2:0]  mResValid;
    logic [63:0] mResDta [3];
    logic        mAf;
    logic        mErr;
    int          mPush, mPop, mNextOcc, mGnt, mPopId;
    logic        mLoad;
    logic [2:0]  mExpReady;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic v, input logic [1:0] cmd,
                                 input logic [21:0] addr, input logic [63:0] dta);
        case (n)
            0: begin bus.c0_req_valid = v; bus.c0_req_cmd = cmd; bus.c0_req_addr = addr; bus.c0_req_dta = dta; end
            1: begin bus.c1_req_valid = v; bus.c1_req_cmd = cmd; bus.c1_req_addr = addr; bus.c1_req_dta = dta; end
            default: begin bus.c2_req_valid = v; bus.c2_req_cmd = cmd; bus.c2_req_addr = addr; bus.c2_req_dta = dta; end
        endcase
    endtask

    task automatic idleAll();
        for (int n = 0; n < 3; n++)
            applyStimulus(n, 1'b0, 2'd0, 22'd0, 64'd0);
        bus.mem_req_rd_en = 1'b0;
        bus.mem_res_wr_en = 1'b0;
        bus.mem_res_wr_dta = 64'd0;
        bus.c0_res_almost_full = 1'b0;
        bus.c1_res_almost_full = 1'b0;
        bus.c2_res_almost_full = 1'b0;
    endtask

    function automatic logic inValid(input int n);
        return (n == 0) ? bus.c0_req_valid : (n == 1) ? bus.c1_req_valid : bus.c2_req_valid;
    endfunction
    function automatic logic [1:0] inCmd(input int n);
        return (n == 0) ? bus.c0_req_cmd : (n == 1) ? bus.c1_req_cmd : bus.c2_req_cmd;
    endfunction
    function automatic logic [21:0] inAddr(input int n);
        return (n == 0) ? bus.c0_req_addr : (n == 1) ? bus.c1_req_addr : bus.c2_req_addr;
    endfunction
    function automatic logic [63:0] inDta(input int n);
        return (n == 0) ? bus.c0_req_dta : (n == 1) ? bus.c1_req_dta : bus.c2_req_dta;
    endfunction
    function automatic logic [63:0] resDta(input int n);
        return (n == 0) ? bus.c0_res_dta : (n == 1) ? bus.c1_res_dta : bus.c2_res_dta;
    endfunction
    function automatic logic [2:0] readyVec();
        return {bus.c2_req_ready, bus.c1_req_ready, bus.c0_req_ready};
    endfunction
    function automatic logic [2:0] resValidVec();
        return {bus.c2_res_valid, bus.c1_res_valid, bus.c0_res_valid};
    endfunction

    function automatic int pickWinner(input int nextOcc);
        bit ok [3];
        for (int n = 0; n < 3; n++)
            ok[n] = inValid(n) && !((inCmd(n) == 2'd2) && (nextOcc >= TAG_DEPTH));
`ifdef MEM_ARB_C0_PRIO_EN
        if (ok[0]) return 0;
        if (ok[1] && ok[2]) return (mLast12 == 1) ? 2 : 1;
        if (ok[1]) return 1;
        if (ok[2]) return 2;
        return -1;
`else
        for (int k = 1; k <= 3; k++)
            if (ok[(mLast + k) % 3]) return (mLast + k) % 3;
        return -1;
`endif
    endfunction

    task automatic modelReset();
        mValid = 1'b0; mCmd = 2'd0; mAddr = 22'd0; mDta = 64'd0; mId = 0;
        tagQ.delete();
        mLast = 2; mLast12 = 2;
        mResValid = 3'b000;
        mAf = 1'b0; mErr = 1'b0;
    endtask

    // Compare and advance the model once per cycle, after inputs settle and before the next rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            checkOutput("reset_head", {bus.mem_req_rd_valid, bus.mem_req_rd_cmd, bus.mem_req_rd_addr, bus.mem_req_rd_dta}, '0);
            checkOutput("reset_flags", {readyVec(), resValidVec(), bus.mem_res_wr_almost_full, bus.err_orphan_rsp}, '0);
            modelReset();
        end else begin
            mPush    = (bus.mem_req_rd_en && mValid && (mCmd == 2'd2)) ? 1 : 0;
            mPop     = (bus.mem_res_wr_en && (tagQ.size() > 0)) ? 1 : 0;
            mNextOcc = tagQ.size() + mPush - mPop;
            mLoad    = !mValid || bus.mem_req_rd_en;
            mGnt     = mLoad ? pickWinner(mNextOcc) : -1;
            mExpReady = (mGnt >= 0) ? (3'b001 << mGnt) : 3'b000;

            checkOutput("rd_valid", bus.mem_req_rd_valid, mValid);
            if (mValid)
                checkOutput("rd_head", {bus.mem_req_rd_cmd, bus.mem_req_rd_addr, bus.mem_req_rd_dta}, {mCmd, mAddr, mDta});
            checkOutput("req_ready", readyVec(), mExpReady);
            checkOutput("res_valid", resValidVec(), mResValid);
            for (int n = 0; n < 3; n++)
                if (mResValid[n]) checkOutput("res_dta", resDta(n), mResDta[n]);
            checkOutput("almost_full", bus.mem_res_wr_almost_full, mAf);
            checkOutput("err_orphan", bus.err_orphan_rsp, mErr);

            mResValid = 3'b000;
            if (bus.mem_res_wr_en) begin
                if (tagQ.size() > 0) begin
                    mPopId = tagQ.pop_front();
                    mResValid = 3'b001 << mPopId;
                    mResDta[mPopId] = bus.mem_res_wr_dta;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (mPush != 0) tagQ.push_back(mId);
            mAf = (mNextOcc >= AF_LEVEL) || bus.c0_res_almost_full || bus.c1_res_almost_full || bus.c2_res_almost_full;
            if (mLoad) begin
`ifdef MEM_ARB_C0_PRIO_EN
                if (mGnt > 0) mLast12 = mGnt;
`else
                if (mGnt >= 0) mLast = mGnt;
`endif
                if ((mGnt >= 0) && (inCmd(mGnt) >= 2'd2)) begin
                    mValid = 1'b1; mCmd = inCmd(mGnt); mAddr = inAddr(mGnt); mDta = inDta(mGnt); mId = mGnt;
                end else begin
                    mValid = 1'b0;
                end
            end
        end
    end

    // Holds reset for one cycle with busy inputs (ready must stay low), then releases it with inputs idle.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++)
            applyStimulus(n, 1'b1, 2'd2, 22'h1, 64'h0);
        bus.mem_req_rd_en = 1'b1;
        bus.mem_res_wr_en = 1'b1;
        #4;
        checkOutput("lit_reset_valid", bus.mem_req_rd_valid, 1'b0);
        checkOutput("lit_reset_ready_err", {readyVec(), bus.err_orphan_rsp}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idleAll();
    endtask

    task automatic testContention();
        doReset();
        for (int n = 0; n < 3; n++)
            applyStimulus(n, 1'b1, 2'd2, 22'(32'h10 * (n + 1)), 64'd0);
        bus.mem_req_rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            checkOutput("lit_contention_ready", readyVec(), 3'b001 << (i % 3));
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++)
            applyStimulus(n, 1'b0, 2'd0, 22'd0, 64'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.mem_res_wr_en  = (i < 6);
            bus.mem_res_wr_dta = 64'h100 + 64'(i);
            #4;
            if (i > 0) checkOutput("lit_tag_order", resValidVec(), 3'b001 << ((i - 1) % 3));
        end
    endtask

    task automatic testRoutingOrphan();
        doReset();
        bus.mem_req_rd_en = 1'b1;
        applyStimulus(1, 1'b1, 2'd2, 22'h000100, 64'd0);
        #4 checkOutput("lit_route_ready1", readyVec(), 3'b010);
        @(negedge clk);
        applyStimulus(1, 1'b0, 2'd0, 22'd0, 64'd0);
        applyStimulus(2, 1'b1, 2'd2, 22'h000200, 64'd0);
        #4 checkOutput("lit_route_head1", {bus.mem_req_rd_valid, bus.mem_req_rd_addr}, {1'b1, 22'h000100});
        @(negedge clk);
        applyStimulus(2, 1'b0, 2'd0, 22'd0, 64'd0);
        @(negedge clk);
        bus.mem_res_wr_en = 1'b1; bus.mem_res_wr_dta = 64'hAAAA;
        @(negedge clk);
        bus.mem_res_wr_dta = 64'hBBBB;
        #4 checkOutput("lit_route_c1", {resValidVec(), bus.c1_res_dta}, {3'b010, 64'hAAAA});
        @(negedge clk);
        bus.mem_res_wr_en = 1'b0;
        #4 checkOutput("lit_route_c2", {resValidVec(), bus.c2_res_dta}, {3'b100, 64'hBBBB});
        @(negedge clk);
        bus.mem_res_wr_en = 1'b1; bus.mem_res_wr_dta = 64'h5555;
        #4 checkOutput("lit_route_pulse_end", {resValidVec(), bus.err_orphan_rsp}, 4'b0000);
        @(negedge clk);
        bus.mem_res_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4 checkOutput("lit_orphan_sticky", {resValidVec(), bus.err_orphan_rsp}, 4'b0001);
            @(negedge clk);
        end
    endtask

    task automatic testBackpressure();
        doReset();
        applyStimulus(0, 1'b1, 2'd3, 22'h123456, 64'hDEADBEEF);
        #4 checkOutput("lit_bp_grant", readyVec(), 3'b001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(0, 1'b0, 2'd0, 22'd0, 64'd0);
            #4 checkOutput("lit_bp_hold", {bus.mem_req_rd_valid, bus.mem_req_rd_cmd, bus.mem_req_rd_addr, bus.mem_req_rd_dta},
                           {1'b1, 2'd3, 22'h123456, 64'hDEADBEEF});
        end
        @(negedge clk);
        bus.mem_req_rd_en = 1'b1;
        #4 checkOutput("lit_bp_last", bus.mem_req_rd_valid, 1'b1);
        @(negedge clk);
        bus.mem_req_rd_en = 1'b0;
        #4 checkOutput("lit_bp_popped", bus.mem_req_rd_valid, 1'b0);
    endtask

    task automatic testTagFull();
        int grants;
        int firstAf;
        grants = 0;
        firstAf = -1;
        doReset();
        applyStimulus(0, 1'b1, 2'd2, 22'h000040, 64'd0);
        bus.mem_req_rd_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (bus.c0_req_ready) grants++;
            if (bus.mem_res_wr_almost_full && (firstAf < 0)) firstAf = i;
        end
        checkOutput("lit_full_grants", 128'(grants), 128'(TAG_DEPTH));
        checkOutput("lit_full_af_start", 128'(firstAf), 128'd13);
        @(negedge clk);
        applyStimulus(1, 1'b1, 2'd3, 22'h0003FF, 64'h77);
        #4 checkOutput("lit_full_write_grant", readyVec(), 3'b010);
        @(negedge clk);
        applyStimulus(1, 1'b0, 2'd0, 22'd0, 64'd0);
        #4 checkOutput("lit_full_write_head", {bus.mem_req_rd_valid, bus.mem_req_rd_cmd, bus.mem_res_wr_almost_full}, 4'b1111);
    endtask

    task automatic testPriority();
        doReset();
        applyStimulus(0, 1'b1, 2'd2, 22'h000011, 64'd0);
        applyStimulus(1, 1'b1, 2'd2, 22'h000022, 64'd0);
        bus.mem_req_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #4;
`ifdef MEM_ARB_C0_PRIO_EN
            checkOutput("lit_prio_grant", readyVec(), 3'b001);
`else
            checkOutput("lit_prio_grant", readyVec(), (i % 2 == 1) ? 3'b010 : 3'b001);
`endif
        end
        @(negedge clk);
        idleAll();
        bus.mem_req_rd_en = 1'b1;
    endtask

    task automatic randomTraffic(input int cycles, input int respPct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 399) != 0);
            for (int n = 0; n < 3; n++)
                applyStimulus(n, $urandom_range(0, 3) != 0,
                              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                              22'($urandom), {$urandom, $urandom});
            bus.mem_req_rd_en  = ($urandom_range(0, 9) < 7);
            bus.mem_res_wr_en  = ($urandom_range(0, 99) < respPct);
            bus.mem_res_wr_dta = {$urandom, $urandom};
            bus.c0_res_almost_full = ($urandom_range(0, 19) == 0);
            bus.c1_res_almost_full = ($urandom_range(0, 19) == 0);
            bus.c2_res_almost_full = ($urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        idleAll();
        testContention();
        testRoutingOrphan();
        testBackpressure();
        testTagFull();
        testPriority();
        randomTraffic(2500, 25);
        randomTraffic(2500, 55);
        @(negedge clk);
        idleAll();
        rst_n = 1'b1;
        @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
